retire_recovery_ctrl: RTL

Sequences branch-mispredict recovery after `stage_retire` raises `mispredict`. It flushes the ROB and restores the freelist in the mispredict cycle, then rebuilds the speculative map table from the architectural map over several cycles. It waits for in-flight functional units to drain, then hands the corrected fetch target to fetch with a valid/ready handshake. Sits between retire, ROB, freelist, map table and fetch; front-end stall is held throughout recovery.

---
 rtl/retire_recovery_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/retire_recovery_ctrl.sv
// retire_recovery_ctrl
//   Sequences branch-mispredict recovery. In the mispredict cycle the ROB is
//   flushed and the freelist restore mask is loaded. The speculative map
//   table is then rebuilt from the architectural map, RESTORE_W entries per
//   cycle. Next the controller waits for in-flight functional units to
//   drain, and finally hands the corrected PC to fetch. The front end is
//   stalled for the whole recovery.
//
// Optional feature: define RECOVERY_PERF_EN to add saturating performance
//   counters perf_recoveries and perf_stall_cycles.
//
// Ports
//   clock                 rising-edge clock
//   reset                 asynchronous, active-low; forces IDLE, all outputs 0
//   mispredict            from retire, same cycle as the offending commit
//   branch_target_in      corrected PC accompanying mispredict
//   arch_table_snapshot   architectural map contents
//   fu_busy               some FU/CDB operation still in flight
//   redirect_ready        fetch accepts the redirect
//   busy                  controller not in IDLE
//   stall_front           hold fetch/dispatch
//   rob_flush             one-cycle ROB flush
//   freelist_restore_en   one-cycle freelist mask load
//   map_restore_en/idx/entry  per-lane speculative map write port
//   redirect_valid/pc     redirect to fetch
//   perf_recoveries, perf_stall_cycles  (RECOVERY_PERF_EN only)
//   state_dbg             current FSM state, for checkers
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

module retire_recovery_ctrl #(
  parameter int ARCH_COUNT = `ARCH_REG_SZ,
  parameter int RESTORE_W  = 4,
  parameter int ADDR_W     = 32,
  parameter int ENTRY_W    = 7,
  parameter int IDX_W      = (ARCH_COUNT > 1) ? $clog2(ARCH_COUNT) : 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 mispredict,
  input  logic [ADDR_W-1:0]                    branch_target_in,
  input  logic [ARCH_COUNT-1:0][ENTRY_W-1:0]   arch_table_snapshot,
  input  logic                                 fu_busy,
  input  logic                                 redirect_ready,
  output logic                                 busy,
  output logic                                 stall_front,
  output logic                                 rob_flush,
  output logic                                 freelist_restore_en,
  output logic [RESTORE_W-1:0]                 map_restore_en,
  output logic [RESTORE_W-1:0][IDX_W-1:0]      map_restore_idx,
  output logic [RESTORE_W-1:0][ENTRY_W-1:0]    map_restore_entry,
  output logic                                 redirect_valid,
  output logic [ADDR_W-1:0]                    redirect_pc,
`ifdef RECOVERY_PERF_EN
  output logic [31:0]                          perf_recoveries,
  output logic [31:0]                          perf_stall_cycles,
`endif
  output logic [1:0]                           state_dbg
);

  // One extra bit so base_q can step past ARCH_COUNT-1 without wrapping.
  localparam int BASE_W = $clog2(ARCH_COUNT) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESTORE  = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   tgt_q;
  logic [BASE_W-1:0]   base_q, base_d;
  logic                load_tgt;
  logic                accept;

  assign state_dbg = state_q;
  assign busy      = (state_q != IDLE);

  // An accepted mispredict is gated by reset so that the combinational
  // flush/restore pulses also read 0 while reset is held.
  assign accept = (state_q == IDLE) && mispredict && reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      if (load_tgt) tgt_q <= branch_target_in;
    end
  end

  // Redirect handshake: redirect_valid and redirect_pc are held stable from
  // the first REDIRECT cycle until the cycle in which redirect_ready is also
  // 1; that cycle is the transfer, and the FSM returns to IDLE after it.
  always_comb begin
    state_d             = state_q;
    base_d              = base_q;
    load_tgt            = 1'b0;
    stall_front         = 1'b0;
    rob_flush           = 1'b0;
    freelist_restore_en = 1'b0;
    map_restore_en      = '0;
    map_restore_idx     = '0;
    map_restore_entry   = '0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Freelist mask is only valid this cycle, so consume it now.
          rob_flush           = 1'b1;
          freelist_restore_en = 1'b1;
          stall_front         = 1'b1;
          load_tgt            = 1'b1;
          base_d              = '0;
          state_d             = RESTORE;
        end
      end
      RESTORE: begin
        stall_front = 1'b1;
        for (int i = 0; i < RESTORE_W; i++) begin
          // Lanes past the end of the table stay disabled on the last pass.
          if (int'(base_q) + i < ARCH_COUNT) begin
            map_restore_en[i]    = 1'b1;
            map_restore_idx[i]   = base_q[IDX_W-1:0] + IDX_W'(i);
            map_restore_entry[i] = arch_table_snapshot[base_q[IDX_W-1:0] + IDX_W'(i)];
          end
        end
        base_d = base_q + BASE_W'(RESTORE_W);
        if (int'(base_q) + RESTORE_W >= ARCH_COUNT) state_d = DRAIN;
      end
      DRAIN: begin
        stall_front = 1'b1;
        if (!fu_busy) state_d = REDIRECT;
      end
      REDIRECT: begin
        stall_front    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt_q;
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RECOVERY_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_recoveries   <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (accept && (perf_recoveries != '1))
        perf_recoveries <= perf_recoveries + 32'd1;
      if (stall_front && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
